serial_uart: RTL
================

Name: serial_uart

Overview:
Byte-wide UART transceiver that sits directly on the SoC serial pins (serialIn/serialOut).
- Converts the async 8N1 line into byte handshakes for the Z8 serial-register logic, and the reverse.
- Runs entirely in the single system clock domain.
- Replaces the processor's bit-banged serial path with a fixed-rate hardware shifter pair.

Parameters:
- clksPerBit, 104: system clocks per bit period. Must be ≥ 4.
- halfBit, clksPerBit/2: RX sampling offset from the start-bit falling edge.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; when reset is asserted, every flop takes its reset value on the next rising edge of clk.
- serialIn  in  1  async RX line, idles high.
- serialOut  out  1  TX line, idles high.
- txData  in  8  byte to send; sampled only in the txStart cycle.
- txStart  in  1  send request; accepted only while txBusy=0.
- txBusy  out  1  high from the cycle after acceptance through the end of the stop bit.
- rxData  out  8  last received byte; held until the next good frame.
- rxReady  out  1  level; set on a good frame, cleared by rxAck.
- rxAck  in  1  consumer acknowledge; clears rxReady next cycle.
- rxOverrun  out  1  sticky; set when a good frame completes while rxReady=1; cleared by rxAck.
- rxFrameErr  out  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
Reset values: serialOut=1, txBusy=0, rxData=0, rxReady=0, rxOverrun=0, rxFrameErr=0. Both FSMs go to IDLE and the bit counters go to 0.
- Reset mid-frame aborts the frame. The line is high in the cycle after reset, and partial RX data is discarded.

TX FSM: IDLE → START → DATA(0..7) → STOP → IDLE.
- In IDLE, txStart=1 latches txData into the shift register.
- Next cycle: serialOut=0, txBusy=1.
- Each state lasts exactly clksPerBit cycles.
- Data is sent LSB first. STOP drives 1.
- After the last STOP cycle, txBusy=0 and the FSM is back in IDLE. txStart can be accepted in that same cycle, giving back-to-back frames with no extra idle bit.
- Total frame: 10·clksPerBit cycles from the first start-bit cycle.
- txStart while txBusy=1 is ignored. No queueing.

RX input stage:
- serialIn passes through a 2-flop synchronizer, plus a third flop used for edge detection.
- Synchronizer flops reset to 1.

RX FSM: IDLE → START → DATA(0..7) → STOP → (IDLE | WAITHIGH).
- IDLE: a synchronized 1→0 edge enters START with the counter at 0.
- START: at halfBit-1 the line is resampled.
  - 1 → glitch, return to IDLE with no output.
  - 0 → enter DATA.
- DATA: each bit is sampled clksPerBit cycles after the previous sample point (mid-bit) and shifted in LSB first.
- STOP sample = 1:
  - rxData ← shift register and rxReady ← 1 on the next edge.
  - If rxReady was already 1 and rxAck is not asserted that cycle, rxOverrun ← 1. rxData is still overwritten (newest byte wins).
  - FSM → IDLE.
- STOP sample = 0: rxFrameErr pulses for 1 cycle, data is discarded, FSM → WAITHIGH.
- WAITHIGH: stays until the synchronized line is 1, then → IDLE. This stops a break condition from being read as a stream of frames.

Simultaneous events:
- rxAck in the same cycle as a good-frame completion: rxReady stays 1, rxOverrun is not set, and the ack applies to the old byte.

Latency:
- Start-bit edge on the pin to rxReady = 2 (sync) + 1 (edge) + halfBit + 9·clksPerBit cycles, ±1.
- TX and RX are fully independent. Full duplex is supported.

Optional Feature:
Macro UART_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit after bit 7, before STOP, making an 11-bit frame.
  - RX samples the parity bit. A mismatch drives a one-cycle pulse on an extra output, rxParityErr (1 bit, reset 0), and the byte is discarded; rxReady is unaffected.
  - The FSMs gain a PARITY state.
- Undefined: 8N1 only. The rxParityErr port and the PARITY state do not exist.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP, WAITHIGH).
  - FRAME_DATA_BITS=8 constant.
  - Bit-counter width derived from clksPerBit via $clog2.
- One natural sub-module: uart_bit_timer.
  - Loadable down-counter with a terminal-count strobe, instantiated once each by TX and RX.
- The top level holds both FSMs and the RX synchronizer.

Test Plan (clksPerBit=8):
- TX 0xA5: pulse txStart with txData=0xA5 → serialOut is 0 for 8 cycles, then bits 1,0,1,0,0,1,0,1 (8 cycles each), then 1 for 8 cycles. txBusy stays high for exactly 80 cycles.
- RX 0x3C: drive an 8N1 frame for 0x3C on serialIn → rxReady rises, rxData=0x3C, rxFrameErr stays 0. rxAck clears rxReady on the next cycle.
- Overrun: send 0x11 then 0x22 without rxAck → rxData=0x22, rxOverrun=1. rxAck clears both rxReady and rxOverrun.
- Glitch and framing:
  - A 2-cycle low pulse on an idle line produces no rxReady.
  - A frame with stop bit=0 gives a single rxFrameErr pulse, and rxData is unchanged.
  - Holding the line low for 30 further cycles produces no further errors.
- Reset mid-frame: assert reset during TX bit 3 and RX bit 5 → serialOut=1 and txBusy=0 the next cycle, rxReady=0. A following clean frame 0x7E is received correctly.
- UART_PARITY_EN: TX 0x07 sends parity bit 1. RX of 0x07 with parity 0 gives an rxParityErr pulse and no rxReady.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings and sizing helpers for serial_uart.
// UART_PARITY_EN adds the PARITY state used by the 8E1 frame variant.
package uart_pkg;

    localparam int FRAME_DATA_BITS = 8;
    localparam int BIT_IDX_W       = $clog2(FRAME_DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP,
        WAITHIGH
    } uartState_t;

    // Width of a down-counter that must hold clksPerBit-1.
    function automatic int bitTimerWidth(input int clksPerBit);
        return (clksPerBit < 2) ? 1 : $clog2(clksPerBit);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable down-counter. tick is high whenever the count is 0,
// so an FSM that reloads on tick sees one tick every (loadValue+1) cycles.
module uart_bit_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    output logic         tick
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/serial_uart.sv
// serial_uart: fixed-rate 8N1 UART transceiver (TX and RX FSMs, RX synchronizer).
// Define UART_PARITY_EN for 8E1 framing and the rxParityErr pulse output.
//
// Handshakes: a TX request is accepted on a rising edge where txStart=1 and
// txBusy=0; txBusy then stays high until the frame ends. rxReady is a level
// "valid": it rises with a new byte on rxData and falls on the edge after the
// consumer holds rxAck=1 (an ack that coincides with a new frame acks the old one).
module serial_uart
    import uart_pkg::*;
#(
    parameter int clksPerBit = 104,
    parameter int halfBit    = clksPerBit / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serialIn,
    output logic       serialOut,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       txBusy,
    output logic [7:0] rxData,
    output logic       rxReady,
    input  logic       rxAck,
    output logic       rxOverrun,
    output logic       rxFrameErr
`ifdef UART_PARITY_EN
    ,
    output logic       rxParityErr
`endif
);

    localparam int                  CNT_W     = bitTimerWidth(clksPerBit);
    localparam logic [CNT_W-1:0]     BIT_LOAD  = CNT_W'(clksPerBit - 1);
    localparam logic [CNT_W-1:0]     HALF_LOAD = CNT_W'(halfBit - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(FRAME_DATA_BITS - 1);

    // ---------------- TX ----------------
    uartState_t           txState, txStateNext;
    logic [7:0]           txShift, txShiftNext;
    logic [BIT_IDX_W-1:0] txBit, txBitNext;
    logic                 txLoad, txTick;
`ifdef UART_PARITY_EN
    logic                 txParity, txParityNext;
`endif

    uart_bit_timer #(.W(CNT_W)) txTimer (
        .clk(clk), .reset(reset), .load(txLoad), .loadValue(BIT_LOAD), .tick(txTick)
    );

    // TX state and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            txState <= IDLE;
            txShift <= '0;
            txBit   <= '0;
`ifdef UART_PARITY_EN
            txParity <= 1'b0;
`endif
        end else begin
            txState <= txStateNext;
            txShift <= txShiftNext;
            txBit   <= txBitNext;
`ifdef UART_PARITY_EN
            txParity <= txParityNext;
`endif
        end
    end

    // TX next-state and line driver; a bit state ends on the timer tick.
    always_comb begin
        txStateNext = txState;
        txShiftNext = txShift;
        txBitNext   = txBit;
        txLoad      = 1'b0;
        serialOut   = 1'b1;
        txBusy      = (txState != IDLE);
`ifdef UART_PARITY_EN
        txParityNext = txParity;
`endif
        case (txState)
            IDLE: begin
                if (txStart) begin
                    txShiftNext = txData;
                    txBitNext   = '0;
                    txLoad      = 1'b1;
                    txStateNext = START;
`ifdef UART_PARITY_EN
                    txParityNext = ^txData;
`endif
                end
            end
            START: begin
                serialOut = 1'b0;
                if (txTick) begin
                    txLoad      = 1'b1;
                    txStateNext = DATA;
                end
            end
            DATA: begin
                serialOut = txShift[0];
                if (txTick) begin
                    txLoad      = 1'b1;
                    txShiftNext = txShift >> 1;
                    if (txBit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        txStateNext = PARITY;
`else
                        txStateNext = STOP;
`endif
                    end else begin
                        txBitNext = txBit + BIT_IDX_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                serialOut = txParity;
                if (txTick) begin
                    txLoad      = 1'b1;
                    txStateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (txTick) begin
                    txStateNext = IDLE;
                end
            end
            default: txStateNext = IDLE;
        endcase
    end

    // ---------------- RX ----------------
    logic                 rxSync1, rxSync2, rxSync3;
    logic                 rxLine, rxFall;
    uartState_t           rxState, rxStateNext;
    logic [7:0]           rxShift, rxShiftNext;
    logic [BIT_IDX_W-1:0] rxBit, rxBitNext;
    logic                 rxLoad, rxTick, rxGood, rxBadStop;
    logic [CNT_W-1:0]     rxLoadValue;
`ifdef UART_PARITY_EN
    logic                 rxParBad, rxParBadNext, rxParFail;
`endif

    assign rxLine = rxSync2;
    assign rxFall = rxSync3 & ~rxSync2;

    uart_bit_timer #(.W(CNT_W)) rxTimer (
        .clk(clk), .reset(reset), .load(rxLoad), .loadValue(rxLoadValue), .tick(rxTick)
    );

    // Two-flop synchronizer plus a history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxSync1 <= 1'b1;
            rxSync2 <= 1'b1;
            rxSync3 <= 1'b1;
        end else begin
            rxSync1 <= serialIn;
            rxSync2 <= rxSync1;
            rxSync3 <= rxSync2;
        end
    end

    // RX next-state: sample mid-bit on each tick, shift in LSB first.
    always_comb begin
        rxStateNext = rxState;
        rxShiftNext = rxShift;
        rxBitNext   = rxBit;
        rxLoad      = 1'b0;
        rxLoadValue = BIT_LOAD;
        rxGood      = 1'b0;
        rxBadStop   = 1'b0;
`ifdef UART_PARITY_EN
        rxParBadNext = rxParBad;
        rxParFail    = 1'b0;
`endif
        case (rxState)
            IDLE: begin
                if (rxFall) begin
                    rxLoad      = 1'b1;
                    rxLoadValue = HALF_LOAD;
                    rxStateNext = START;
                end
            end
            START: begin
                if (rxTick) begin
                    if (rxLine) begin
                        rxStateNext = IDLE;
                    end else begin
                        rxLoad      = 1'b1;
                        rxBitNext   = '0;
                        rxStateNext = DATA;
`ifdef UART_PARITY_EN
                        rxParBadNext = 1'b0;
`endif
                    end
                end
            end
            DATA: begin
                if (rxTick) begin
                    rxLoad      = 1'b1;
                    rxShiftNext = {rxLine, rxShift[7:1]};
                    if (rxBit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rxStateNext = PARITY;
`else
                        rxStateNext = STOP;
`endif
                    end else begin
                        rxBitNext = rxBit + BIT_IDX_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (rxTick) begin
                    rxLoad       = 1'b1;
                    rxParFail    = (rxLine != ^rxShift);
                    rxParBadNext = rxParFail;
                    rxStateNext  = STOP;
                end
            end
`endif
            STOP: begin
                if (rxTick) begin
                    if (rxLine) begin
`ifdef UART_PARITY_EN
                        rxGood = ~rxParBad;
`else
                        rxGood = 1'b1;
`endif
                        rxStateNext = IDLE;
                    end else begin
                        rxBadStop   = 1'b1;
                        rxStateNext = WAITHIGH;
                    end
                end
            end
            WAITHIGH: begin
                if (rxLine) begin
                    rxStateNext = IDLE;
                end
            end
            default: rxStateNext = IDLE;
        endcase
    end

    // RX state, shift register and consumer-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxState    <= IDLE;
            rxShift    <= '0;
            rxBit      <= '0;
            rxData     <= '0;
            rxReady    <= 1'b0;
            rxOverrun  <= 1'b0;
            rxFrameErr <= 1'b0;
`ifdef UART_PARITY_EN
            rxParBad    <= 1'b0;
            rxParityErr <= 1'b0;
`endif
        end else begin
            rxState    <= rxStateNext;
            rxShift    <= rxShiftNext;
            rxBit      <= rxBitNext;
            rxFrameErr <= rxBadStop;
`ifdef UART_PARITY_EN
            rxParBad    <= rxParBadNext;
            rxParityErr <= rxParFail;
`endif
            if (rxGood) begin
                // Newest byte wins; an ack in this cycle consumes the old byte.
                rxData    <= rxShift;
                rxReady   <= 1'b1;
                rxOverrun <= (rxOverrun | rxReady) & ~rxAck;
            end else if (rxAck) begin
                rxReady   <= 1'b0;
                rxOverrun <= 1'b0;
            end
        end
    end

endmodule
